gain_control: RTL and testbench

//  Master-volume stage between the audio-in stream and the DAC-out stream of the mixer.

---
 rtl/gain_control.sv | 235 +++++++++++++++++++++++
 tb/tb_gain_control.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gain_control.sv
// gain_control
//   Master-volume stage sitting between the mixer's audio-in stream and the
//   DAC-out stream. Two active-low keys raise and lower a saturating gain
//   level from 0 to MAX_LEVEL. Each accepted sample is multiplied by level/4,
//   so level 4 is unity gain, and the result saturates to the sample range.
//   The current level is shown on one active-low 7-segment digit.
//
// Parameters
//   DATA_W          signed sample width
//   MAX_LEVEL       highest gain level (must be <= 9 to fit one digit)
//   RESET_LEVEL     level after reset
//   DEBOUNCE_CYCLES cycles a key must differ from its stable state to flip it
//   REPEAT_CYCLES   auto-repeat period while a key is held
//
// Ports
//   clk_clk        in   system clock
//   reset_reset_n  in   asynchronous active-low reset
//   gain_key[1:0]  in   raw keys, active-low, asynchronous: [0]=up, [1]=down
//   gain_hex[6:0]  out  segments {g,f,e,d,c,b,a}, active-low
//   gain_level     out  current gain level, binary
//   sink_*         in   input sample stream (data, channel, valid) / ready out
//   source_*       out  scaled sample stream (data, channel, valid) / ready in
//
// Build option
//   GAIN_KEY_AUTOREPEAT_EN  when defined, a key held stably pressed produces
//                           an extra press event every REPEAT_CYCLES cycles.

module gain_control #(
    parameter int DATA_W          = 24,
    parameter int MAX_LEVEL       = 8,
    parameter int RESET_LEVEL     = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [1:0]        gain_key,
    output logic [6:0]        gain_hex,
    output logic [3:0]        gain_level,
    input  logic [DATA_W-1:0] sink_data,
    input  logic              sink_channel,
    input  logic              sink_valid,
    output logic              sink_ready,
    output logic [DATA_W-1:0] source_data,
    output logic              source_channel,
    output logic              source_valid,
    input  logic              source_ready
);

    localparam int              DB_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]      LEVEL_MAX = 4'(MAX_LEVEL);
    localparam logic [3:0]      LEVEL_RST = 4'(RESET_LEVEL);

    // Saturation bounds expressed at the widened product width.
    localparam logic signed [DATA_W+3:0] SAT_MAX = {5'b00000, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W+3:0] SAT_MIN = {5'b11111, {(DATA_W-1){1'b0}}};

    // Reject configurations the counters and the single digit cannot represent.
    if (MAX_LEVEL > 9 || RESET_LEVEL > MAX_LEVEL || DEBOUNCE_CYCLES < 2 ||
        REPEAT_CYCLES < 2) begin : g_bad_params
        $error("gain_control: unsupported parameter combination");
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Key synchronisation and debounce
    // ------------------------------------------------------------------
    // Keys idle high, so the synchronisers reset to the released level.
    logic [1:0] key_meta;
    logic [1:0] key_sync;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            key_meta <= 2'b11;
            key_sync <= 2'b11;
        end else begin
            key_meta <= gain_key;
            key_sync <= key_meta;
        end
    end

    logic [1:0]           key_pressed;
    logic [1:0]           key_stable;
    logic [1:0][DB_W-1:0] db_cnt;
    logic [1:0]           db_press_evt;
    logic [1:0]           press_evt;

    assign key_pressed = ~key_sync;

    // A key must disagree with its stable state for DEBOUNCE_CYCLES
    // consecutive cycles before the stable state flips; any agreement in
    // between restarts the count. Only the released->pressed flip emits an
    // event.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            key_stable   <= 2'b00;
            db_cnt       <= '0;
            db_press_evt <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                db_press_evt[i] <= 1'b0;
                if (key_pressed[i] != key_stable[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        key_stable[i]   <= key_pressed[i];
                        db_cnt[i]       <= '0;
                        db_press_evt[i] <= key_pressed[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

`ifdef GAIN_KEY_AUTOREPEAT_EN
    localparam int              RP_W    = $clog2(REPEAT_CYCLES);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

    logic [1:0][RP_W-1:0] rep_cnt;
    logic [1:0]           rep_evt;

    // The counter is held clear on the cycle the key becomes stable, so the
    // first repeat lands exactly REPEAT_CYCLES after the initial event.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rep_cnt <= '0;
            rep_evt <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rep_evt[i] <= 1'b0;
                if (!key_stable[i]) begin
                    rep_cnt[i] <= '0;
                end else if (rep_cnt[i] == RP_LAST) begin
                    rep_cnt[i] <= '0;
                    rep_evt[i] <= 1'b1;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + RP_W'(1);
                end
            end
        end
    end

    assign press_evt = db_press_evt | rep_evt;
`else
    assign press_evt = db_press_evt;
`endif

    // ------------------------------------------------------------------
    // Gain level and display
    // ------------------------------------------------------------------
    // Simultaneous up and down events cancel out.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            gain_level <= LEVEL_RST;
        end else begin
            case (press_evt)
                2'b01: if (gain_level < LEVEL_MAX) gain_level <= gain_level + 4'd1;
                2'b10: if (gain_level != 4'd0)     gain_level <= gain_level - 4'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            gain_hex <= seg_decode(LEVEL_RST);
        end else begin
            gain_hex <= seg_decode(gain_level);
        end
    end

    // ------------------------------------------------------------------
    // Sample scaling
    // ------------------------------------------------------------------
    // |data| * 9 < 2^(DATA_W+3), so DATA_W+4 signed bits hold the product
    // without overflow; >>> 2 floors toward minus infinity.
    logic signed [DATA_W+3:0] data_ext;
    logic signed [DATA_W+3:0] level_ext;
    logic signed [DATA_W+3:0] scaled;
    logic        [DATA_W-1:0] scaled_sat;
    logic                     accept;

    assign data_ext  = {{4{sink_data[DATA_W-1]}}, sink_data};
    assign level_ext = {{DATA_W{1'b0}}, gain_level};
    assign scaled    = (data_ext * level_ext) >>> 2;

    always_comb begin
        scaled_sat = scaled[DATA_W-1:0];
        if (scaled > SAT_MAX) begin
            scaled_sat = SAT_MAX[DATA_W-1:0];
        end else if (scaled < SAT_MIN) begin
            scaled_sat = SAT_MIN[DATA_W-1:0];
        end
    end

    assign sink_ready = !source_valid || source_ready;
    assign accept     = sink_valid && sink_ready;

    // Single-entry output register; the level in effect at acceptance is
    // baked into the stored sample.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            source_data    <= '0;
            source_channel <= 1'b0;
            source_valid   <= 1'b0;
        end else if (accept) begin
            source_data    <= scaled_sat;
            source_channel <= sink_channel;
            source_valid   <= 1'b1;
        end else if (source_ready) begin
            source_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gain_control.sv
// tb_gain_control
//   Directed bench for gain_control with short debounce and repeat periods.
//   Covers reset values, debounce filtering, level saturation, scaling and
//   clamping, backpressure ordering, mid-stream reset and key auto-repeat.

module tb_gain_control;

    localparam int DATA_W = 24;

    logic              clk_clk = 1'b0;
    logic              reset_reset_n;
    logic [1:0]        gain_key;
    logic [6:0]        gain_hex;
    logic [3:0]        gain_level;
    logic [DATA_W-1:0] sink_data;
    logic              sink_channel;
    logic              sink_valid;
    logic              sink_ready;
    logic [DATA_W-1:0] source_data;
    logic              source_channel;
    logic              source_valid;
    logic              source_ready;

    int test_count = 0;
    int fail_count = 0;

    always #5 clk_clk = ~clk_clk;

    gain_control #(
        .DATA_W          (DATA_W),
        .MAX_LEVEL       (8),
        .RESET_LEVEL     (4),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (16)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .gain_key       (gain_key),
        .gain_hex       (gain_hex),
        .gain_level     (gain_level),
        .sink_data      (sink_data),
        .sink_channel   (sink_channel),
        .sink_valid     (sink_valid),
        .sink_ready     (sink_ready),
        .source_data    (source_data),
        .source_channel (source_channel),
        .source_valid   (source_valid),
        .source_ready   (source_ready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Holds the selected keys low for low_cycles clock edges, releases them
    // and waits long enough for debounce, level and display to settle.
    task automatic applyStimulus(input logic [1:0] press, input int low_cycles);
        @(negedge clk_clk);
        gain_key = ~press;
        repeat (low_cycles) @(negedge clk_clk);
        gain_key = 2'b11;
        repeat (12) @(negedge clk_clk);
    endtask

    // One sample through an idle stage with the sink always ready.
    task automatic send_sample(input string tag, input logic [DATA_W-1:0] data,
                               input logic ch, input logic [DATA_W-1:0] expected);
        @(negedge clk_clk);
        source_ready = 1'b1;
        sink_valid   = 1'b1;
        sink_data    = data;
        sink_channel = ch;
        @(negedge clk_clk);
        sink_valid = 1'b0;
        checkOutput({tag, "_valid"}, 32'(source_valid), 32'd1);
        checkOutput({tag, "_data"}, 32'(source_data), 32'(expected));
        checkOutput({tag, "_chan"}, 32'(source_channel), 32'(ch));
        @(negedge clk_clk);
        checkOutput({tag, "_drain"}, 32'(source_valid), 32'd0);
    endtask

    logic [DATA_W-1:0] exp_data_q[$];
    logic              exp_ch_q[$];
    logic [DATA_W-1:0] held_data;
    logic              held_ch;
    logic              stalled;
    logic [DATA_W-1:0] pop_data;
    logic              pop_ch;
    int                sent;
    int                got;

    initial begin
        reset_reset_n = 1'b0;
        gain_key      = 2'b11;
        sink_data     = '0;
        sink_channel  = 1'b0;
        sink_valid    = 1'b0;
        source_ready  = 1'b1;

        @(negedge clk_clk);
        checkOutput("rst_level", 32'(gain_level), 32'd4);
        checkOutput("rst_hex", 32'(gain_hex), 32'h19);
        checkOutput("rst_valid", 32'(source_valid), 32'd0);
        checkOutput("rst_data", 32'(source_data), 32'd0);
        checkOutput("rst_chan", 32'(source_channel), 32'd0);
        reset_reset_n = 1'b1;
        repeat (2) @(negedge clk_clk);

        send_sample("unity_pos", 24'h100000, 1'b0, 24'h100000);
        send_sample("unity_neg", 24'hFFFFF0, 1'b1, 24'hFFFFF0);

        applyStimulus(2'b01, 3);
        checkOutput("glitch_level", 32'(gain_level), 32'd4);
        applyStimulus(2'b01, 6);
        checkOutput("press_level", 32'(gain_level), 32'd5);
        checkOutput("press_hex", 32'(gain_hex), 32'h12);

        for (int n = 0; n < 5; n++) applyStimulus(2'b01, 6);
        checkOutput("sat_hi_level", 32'(gain_level), 32'd8);
        checkOutput("sat_hi_hex", 32'(gain_hex), 32'h00);

        send_sample("x2_clamp_hi", 24'h500000, 1'b0, 24'h7FFFFF);
        send_sample("x2_clamp_lo", 24'h900000, 1'b1, 24'h800000);
        send_sample("x2_small", 24'h000003, 1'b0, 24'h000006);

        applyStimulus(2'b11, 6);
        checkOutput("both_level", 32'(gain_level), 32'd8);

        for (int n = 0; n < 7; n++) applyStimulus(2'b10, 6);
        checkOutput("down7_level", 32'(gain_level), 32'd1);
        checkOutput("down7_hex", 32'(gain_hex), 32'h79);
        send_sample("quarter_neg", 24'hFFFFFD, 1'b1, 24'hFFFFFF);

        for (int n = 0; n < 3; n++) applyStimulus(2'b10, 6);
        checkOutput("sat_lo_level", 32'(gain_level), 32'd0);
        checkOutput("sat_lo_hex", 32'(gain_hex), 32'h40);
        send_sample("mute", 24'h123456, 1'b0, 24'h000000);

        // Park a sample behind a stalled sink, then reset asynchronously.
        @(negedge clk_clk);
        source_ready = 1'b0;
        sink_valid   = 1'b1;
        sink_data    = 24'h222222;
        sink_channel = 1'b1;
        @(negedge clk_clk);
        sink_valid = 1'b0;
        checkOutput("pre_rst_valid", 32'(source_valid), 32'd1);
        #2 reset_reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(source_valid), 32'd0);
        checkOutput("mid_rst_level", 32'(gain_level), 32'd4);
        checkOutput("mid_rst_hex", 32'(gain_hex), 32'h19);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        source_ready  = 1'b1;
        @(negedge clk_clk);

        // Continuous input with source_ready cycling 1,0,0,1; unity gain so
        // every delivered sample must equal the accepted input in order.
        sent    = 0;
        got     = 0;
        stalled = 1'b0;
        held_data = '0;
        held_ch   = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk_clk);
            source_ready = (cyc >= 32) || (cyc % 4 == 0) || (cyc % 4 == 3);
            if (cyc < 32) begin
                sink_valid   = 1'b1;
                sink_data    = 24'(sent * 24'h010203 + 5);
                sink_channel = sent[0];
            end else begin
                sink_valid = 1'b0;
            end
            #1;
            if (stalled) begin
                checkOutput("bp_hold_data", 32'(source_data), 32'(held_data));
                checkOutput("bp_hold_chan", 32'(source_channel), 32'(held_ch));
            end
            if (source_valid && source_ready) begin
                if (exp_data_q.size() == 0) begin
                    checkOutput("bp_extra_output", 32'd1, 32'd0);
                end else begin
                    pop_data = exp_data_q.pop_front();
                    pop_ch   = exp_ch_q.pop_front();
                    checkOutput("bp_data", 32'(source_data), 32'(pop_data));
                    checkOutput("bp_chan", 32'(source_channel), 32'(pop_ch));
                end
                got++;
            end
            stalled   = source_valid && !source_ready;
            held_data = source_data;
            held_ch   = source_channel;
            if (sink_valid && sink_ready) begin
                exp_data_q.push_back(sink_data);
                exp_ch_q.push_back(sink_channel);
                sent++;
            end
        end
        checkOutput("bp_accepted", 32'(sent), 32'd16);
        checkOutput("bp_delivered", 32'(got), 32'd16);
        checkOutput("bp_leftover", 32'(exp_data_q.size()), 32'd0);

        applyStimulus(2'b01, 44);
`ifdef GAIN_KEY_AUTOREPEAT_EN
        checkOutput("hold_level", 32'(gain_level), 32'd7);
        checkOutput("hold_hex", 32'(gain_hex), 32'h78);
`else
        checkOutput("hold_level", 32'(gain_level), 32'd5);
        checkOutput("hold_hex", 32'(gain_hex), 32'h12);
`endif

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
